divider_controller: RTL and testbench
=====================================

# divider_controller

Synchronous controller that sequences the team's counter/divider datapath. It holds a configuration (divide ratio N and optional burst length M), starts and stops counting on command, and emits one-cycle `tick` enables every N clocks. It also drives a T-style `phase` output that toggles on every tick (a divide-by-2N clock-enable) and a tick counter. It sits between the control logic that programs the divider and the downstream stages that consume `tick`/`phase` in place of ripple-derived clocks.

## Interface
Parameters:
- `DIV_W`, default 8: width of the divide-ratio field.
- `CNT_W`, default 8: width of the burst length and of the tick counter.

Ports:
- `clk`, in, 1: single system clock; all state changes on its rising edge.
- `Rst`, in, 1: reset, asynchronous and active-high.
- `cfg_valid`, in, 1: configuration offered.
- `cfg_ready`, out, 1: configuration can be accepted (high only in IDLE).
- `cfg_div`, in, DIV_W: divide ratio N; 0 is treated as 1.
- `cfg_ticks`, in, CNT_W: burst length M; 0 means free-run.
- `start`, in, 1: begin counting with the stored config.
- `stop`, in, 1: abort counting.
- `busy`, out, 1: high in RUN.
- `tick`, out, 1: one-cycle pulse every N clocks while running.
- `done`, out, 1: one-cycle pulse coincident with the M-th tick of a burst.
- `phase`, out, 1: toggles on each tick.
- `count`, out, CNT_W: ticks emitted since the last start.

## Operation
- States: IDLE and RUN.
- Reset values: IDLE; `busy`=0, `tick`=0, `done`=0, `phase`=0, `count`=0, `cfg_ready`=1. Stored N=1, M=0.
- Config handshake: the transfer happens on an edge where `cfg_valid && cfg_ready`. `cfg_ready` is combinational and equals (state==IDLE). Offers made in RUN are held off and not lost; the source keeps `cfg_valid` asserted.
- IDLE→RUN: on an edge with `start`=1 and `stop`=0. On that edge the prescaler, `count` and `phase` clear to 0.
- Config and start in the same cycle: the config is accepted and the run uses the new N/M.
- `start` and `stop` in the same cycle in IDLE: stop wins and the block stays IDLE.
- `start` while in RUN is ignored.
- Prescaler counts 0..N-1. When it reaches N-1 it wraps to 0 and a tick is issued.
- On each tick: `count` increments, wrapping mod 2^CNT_W in free-run, and `phase` inverts.
- Burst (M>0): the M-th tick also asserts `done`, and the state returns to IDLE on the same edge that registers `tick`/`done`.
- Free-run (M=0): runs until `stop`; `done` never asserts.
- `stop` in RUN: returns to IDLE at the next edge. `count` and `phase` hold their values and no `done` is issued.
- `stop` coincident with the final burst tick: the tick and `done` are still issued.
- `Rst` mid-run: all outputs and stored config return to reset values immediately, with no `done`.

## Timing
- `tick`, `done`, `phase`, `count` and `busy` are registered outputs.
- Start sampled at edge k: the first `tick` is high in the cycle following edge k+N. Subsequent ticks follow every N cycles.
- N=1: `tick` is high on every cycle from edge k+1 onward.
- Burst of M ticks: `done` is high in the cycle following edge k+M·N, and `busy` falls on that same edge.
- Back-to-back bursts: a `start` presented in the cycle `done` is high is sampled in IDLE and starts the next burst immediately.

## Structure
- Package `divider_ctrl_pkg` holds:
  - the state enum (IDLE, RUN);
  - reset constants `DEF_DIV`=1 and `DEF_TICKS`=0;
  - the helper function that maps N=0 to 1.
- Sub-module `mod_n_counter`: loadable modulo-N prescaler with clear and a wrap strobe. The FSM, config registers, tick counter and phase toggle live in the top level.

## Test plan
- Reset, then configure N=4, M=3, then start: ticks at cycles 4, 8 and 12 after start; `done` with the third tick; `count`=3; `phase`=1; `busy` falls.
- N=0, M=0, start: a tick on every cycle; after 300 ticks `count`=44 (wrap at 256); `stop` → IDLE with `count` held.
- In RUN, `cfg_valid` with N=7: `cfg_ready`=0 and no change. After `stop` the config is accepted; the next run ticks every 7 cycles.
- `stop` on the cycle of the final burst tick (N=2, M=2): `tick` and `done` both still pulse.
- `start` and `stop` together in IDLE: stays IDLE. `start` during RUN: no restart and the tick cadence is unchanged.
- Assert `Rst` midway through an N=5, M=10 burst: outputs go to 0 asynchronously with no `done`; after release, a start runs with N=1, free-run.

Source files
------------

// File: rtl/divider_ctrl_pkg.sv
// Shared types, reset constants and helpers for the divider controller.
package divider_ctrl_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DEF_DIV   = 1;
   localparam int DEF_TICKS = 0;

   // A divide ratio of zero behaves exactly like a ratio of one.
   function automatic logic [31:0] norm_div(input logic [31:0] d);
      return (d == 32'd0) ? 32'd1 : d;
   endfunction

endpackage

// File: rtl/divider_controller_mod_n_counter.sv
// Modulo-N prescaler: counts 0..limit while enabled and strobes wrap on limit.
module mod_n_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] limit,
   output logic         wrap
);

   logic [W-1:0] value_r;

   assign wrap = en && (value_r == limit);

   // Prescaler state; clear has priority over counting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_r <= W'(0);
      end else if (clr) begin
         value_r <= W'(0);
      end else if (en) begin
         if (value_r == limit) begin
            value_r <= W'(0);
         end else begin
            value_r <= value_r + W'(1);
         end
      end else begin
         value_r <= value_r;
      end
   end

endmodule

// File: rtl/divider_controller.sv
// Run/idle sequencer for the divider datapath: config capture, tick, phase and burst counting.
module divider_controller
   import divider_ctrl_pkg::*;
#(
   parameter int DIV_W = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             Rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic [CNT_W-1:0] cfg_ticks,
   input  logic             start,
   input  logic             stop,
   output logic             busy,
   output logic             tick,
   output logic             done,
   output logic             phase,
   output logic [CNT_W-1:0] count
);

   state_t           state_r;
   logic [DIV_W-1:0] div_r;
   logic [CNT_W-1:0] ticks_r;
   logic             busy_r;
   logic             tick_r;
   logic             done_r;
   logic             phase_r;
   logic [CNT_W-1:0] count_r;

   logic             start_go_s;
   logic             wrap_s;
   logic             final_s;
   logic             tick_go_s;
   logic [CNT_W-1:0] next_count_s;
   logic [DIV_W-1:0] limit_s;

   assign cfg_ready = (state_r == IDLE);
   assign busy      = busy_r;
   assign tick      = tick_r;
   assign done      = done_r;
   assign phase     = phase_r;
   assign count     = count_r;
   assign limit_s   = div_r - DIV_W'(1);

   mod_n_counter #(.W(DIV_W)) u_prescaler (
      .clk   (clk),
      .rst   (Rst),
      .clr   (start_go_s),
      .en    (state_r == RUN),
      .limit (limit_s),
      .wrap  (wrap_s)
   );

   // Start qualification and tick/burst-end decode.
   always_comb begin
      start_go_s   = 1'b0;
      final_s      = 1'b0;
      tick_go_s    = 1'b0;
      next_count_s = count_r + CNT_W'(1);
      if (state_r == IDLE) begin
         start_go_s = start && !stop;
      end else begin
         start_go_s = 1'b0;
      end
      // The final burst tick survives a coincident stop; other ticks do not.
      final_s   = wrap_s && (ticks_r != CNT_W'(0)) && (next_count_s == ticks_r);
      tick_go_s = wrap_s && (!stop || final_s);
   end

   // Controller FSM with its registered outputs and stored configuration.
   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         state_r <= IDLE;
         div_r   <= DIV_W'(DEF_DIV);
         ticks_r <= CNT_W'(DEF_TICKS);
         busy_r  <= 1'b0;
         tick_r  <= 1'b0;
         done_r  <= 1'b0;
         phase_r <= 1'b0;
         count_r <= CNT_W'(0);
      end else begin
         tick_r <= 1'b0;
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (cfg_valid) begin
                  div_r   <= DIV_W'(norm_div(32'(cfg_div)));
                  ticks_r <= cfg_ticks;
               end
               if (start_go_s) begin
                  state_r <= RUN;
                  busy_r  <= 1'b1;
                  count_r <= CNT_W'(0);
                  phase_r <= 1'b0;
               end
            end
            RUN: begin
               if (tick_go_s) begin
                  tick_r  <= 1'b1;
                  count_r <= next_count_s;
                  phase_r <= ~phase_r;
               end
               if (final_s) begin
                  done_r  <= 1'b1;
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end else if (stop) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_divider_controller.sv
// Directed-vector bench for divider_controller with hand-computed expectations.
module tb_divider_controller;

   logic       clk;
   logic       rst;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [7:0] cfg_div;
   logic [7:0] cfg_ticks;
   logic       start;
   logic       stop;
   logic       busy;
   logic       tick;
   logic       done;
   logic       phase;
   logic [7:0] count;

   int n_cmp = 0;
   int n_err = 0;

   divider_controller #(.DIV_W(8), .CNT_W(8)) dut (
      .clk       (clk),
      .Rst       (rst),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_div   (cfg_div),
      .cfg_ticks (cfg_ticks),
      .start     (start),
      .stop      (stop),
      .busy      (busy),
      .tick      (tick),
      .done      (done),
      .phase     (phase),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; cfg_valid = 1'b0; cfg_div = 8'd0; cfg_ticks = 8'd0;
      start = 1'b0; stop = 1'b0;
      #3;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_tick", 32'(tick), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_phase", 32'(phase), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_ready", 32'(cfg_ready), 32'd1);
      step(); step();
      rst = 1'b0;

      // N=4, M=3 burst
      cfg_valid = 1'b1; cfg_div = 8'd4; cfg_ticks = 8'd3;
      step();
      cfg_valid = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_count0", 32'(count), 32'd0);
      for (int j = 1; j <= 12; j++) begin
         step();
         check("t1_tick", 32'(tick), 32'(j % 4 == 0));
         check("t1_done", 32'(done), 32'(j == 12));
      end
      check("t1_count", 32'(count), 32'd3);
      check("t1_phase", 32'(phase), 32'd1);
      check("t1_busy_end", 32'(busy), 32'd0);

      // N=0 free-run, config and start together
      cfg_valid = 1'b1; cfg_div = 8'd0; cfg_ticks = 8'd0; start = 1'b1;
      step();
      cfg_valid = 1'b0; start = 1'b0;
      for (int j = 1; j <= 300; j++) begin
         step();
         if (j <= 3) check("t2_tick", 32'(tick), 32'd1);
      end
      check("t2_tick300", 32'(tick), 32'd1);
      check("t2_count", 32'(count), 32'd44);
      check("t2_phase", 32'(phase), 32'd0);
      check("t2_done", 32'(done), 32'd0);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("t2_busy", 32'(busy), 32'd0);
      check("t2_count_hold", 32'(count), 32'd44);
      step();
      check("t2_count_hold2", 32'(count), 32'd44);

      // Config offered during RUN is held off
      start = 1'b1;
      step();
      start = 1'b0;
      cfg_valid = 1'b1; cfg_div = 8'd7; cfg_ticks = 8'd0;
      #1;
      check("t3_ready_run", 32'(cfg_ready), 32'd0);
      step(); step();
      check("t3_tick_n1", 32'(tick), 32'd1);
      check("t3_ready_run2", 32'(cfg_ready), 32'd0);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("t3_idle", 32'(busy), 32'd0);
      check("t3_ready_idle", 32'(cfg_ready), 32'd1);
      step();
      cfg_valid = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      for (int j = 1; j <= 14; j++) begin
         step();
         check("t3_tick7", 32'(tick), 32'(j % 7 == 0));
      end
      check("t3_count", 32'(count), 32'd2);
      stop = 1'b1;
      step();
      stop = 1'b0;

      // Stop coincident with the final burst tick (N=2, M=2)
      cfg_valid = 1'b1; cfg_div = 8'd2; cfg_ticks = 8'd2;
      step();
      cfg_valid = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      step(); check("t4_tick1", 32'(tick), 32'd0);
      step(); check("t4_tick2", 32'(tick), 32'd1);
      step(); check("t4_tick3", 32'(tick), 32'd0);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("t4_tick_final", 32'(tick), 32'd1);
      check("t4_done", 32'(done), 32'd1);
      check("t4_busy", 32'(busy), 32'd0);
      check("t4_count", 32'(count), 32'd2);
      check("t4_phase", 32'(phase), 32'd0);

      // start+stop in IDLE, then start during RUN
      start = 1'b1; stop = 1'b1;
      step();
      start = 1'b0; stop = 1'b0;
      check("t5_stay_idle", 32'(busy), 32'd0);
      start = 1'b1;
      step();
      start = 1'b0;
      check("t5_busy", 32'(busy), 32'd1);
      step(); check("t5_tick1", 32'(tick), 32'd0);
      start = 1'b1;
      step();
      start = 1'b0;
      check("t5_tick2", 32'(tick), 32'd1);
      check("t5_count2", 32'(count), 32'd1);
      step(); check("t5_tick3", 32'(tick), 32'd0);
      step();
      check("t5_tick4", 32'(tick), 32'd1);
      check("t5_done", 32'(done), 32'd1);
      check("t5_count4", 32'(count), 32'd2);

      // Reset mid-burst (N=5, M=10)
      cfg_valid = 1'b1; cfg_div = 8'd5; cfg_ticks = 8'd10;
      step();
      cfg_valid = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      repeat (17) step();
      check("t6_count_pre", 32'(count), 32'd3);
      check("t6_phase_pre", 32'(phase), 32'd1);
      rst = 1'b1;
      #2;
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_count", 32'(count), 32'd0);
      check("t6_phase", 32'(phase), 32'd0);
      check("t6_tick", 32'(tick), 32'd0);
      check("t6_ready", 32'(cfg_ready), 32'd1);
      step();
      check("t6_done", 32'(done), 32'd0);
      rst = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      step(); check("t6_n1_tick1", 32'(tick), 32'd1);
      step();
      check("t6_n1_tick2", 32'(tick), 32'd1);
      check("t6_n1_count", 32'(count), 32'd2);
      check("t6_n1_done", 32'(done), 32'd0);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("t6_stop", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
